// File: rtl/bin_to_bcd_seq_pkg.sv
// bcd_pkg: shared FSM states, nibble width and DIGITS sizing check for bin_to_bcd_seq
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_NIBBLE_W = 4;
  function automatic bit digits_ok(input int width, input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p > ((longint'(1) << width) - 1);
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the digit is 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] d,
  output logic [BCD_NIBBLE_W-1:0] q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary to packed BCD converter with start/done
// handshake; define BIN_TO_BCD_SIGNED_EN to treat bin as two's complement and report neg.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0]               bin,
  output logic                           busy,
  output logic                           done,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd,
  output logic                           neg
);
  localparam int BW = BCD_NIBBLE_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  if (WIDTH < 4 || WIDTH > 16 || !digits_ok(WIDTH, DIGITS)) begin : g_bad_cfg
    $error("bin_to_bcd_seq: illegal WIDTH/DIGITS combination");
  end
  state_t            state, state_nx;
  logic [CW-1:0]     count;
  logic [BW-1:0]     scratch, adj;
  logic [WIDTH-1:0]  sh, mag;
  logic [BW+WIDTH-1:0] shifted;
  logic              accept, last;
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d(scratch[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .q(adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end
  assign shifted = {adj, sh} << 1;
  assign accept  = start && (state != SHIFT);
  assign last    = (count == CW'(WIDTH - 1));
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);
`ifdef BIN_TO_BCD_SIGNED_EN
  logic neg_pending;
  // -bin wraps the most negative value onto its own unsigned magnitude
  assign mag = bin[WIDTH-1] ? -bin : bin;
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_pending <= 1'b0;
      neg         <= 1'b0;
    end else begin
      if (accept) neg_pending <= bin[WIDTH-1];
      if (state == SHIFT && last) neg <= neg_pending;
    end
  end
`else
  assign mag = bin;
  assign neg = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = accept ? SHIFT : (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      scratch <= '0;
      sh      <= '0;
      bcd     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        count   <= '0;
        scratch <= '0;
        sh      <= mag;
      end else if (state == SHIFT) begin
        count          <= count + 1'b1;
        {scratch, sh}  <= shifted;
        if (last) bcd <= shifted[BW+WIDTH-1 -: BW];
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed scoreboard bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3)
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy, done, neg;
  logic [11:0] bcd;
  logic [12:0] sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_done = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] model(input logic [7:0] b);
    int v;
    logic ng;
`ifdef BIN_TO_BCD_SIGNED_EN
    ng = b[7];
    v  = ng ? 256 - int'(b) : int'(b);
`else
    ng = 1'b0;
    v  = int'(b);
`endif
    return {ng, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      logic [12:0] e;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bcd), 32'hdead);
      end else begin
        e = sb.pop_front();
        check("bcd", 32'(bcd), 32'(e[11:0]));
        check("neg", 32'(neg), 32'(e[12]));
      end
    end
  end

  // drive start for one cycle, then measure cycles (accept cycle = 1) until done
  task automatic convert(input logic [7:0] b);
    int lat, nbusy;
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    sb.push_back(model(b));
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end
    check("latency", 32'(lat), 32'd9);
    check("busy_cycles", 32'(nbusy), 32'd8);
  endtask

  initial begin
    int d1, d2, nlow, nd;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    convert(8'd0);
    convert(8'd255);
    convert(8'd100);
    convert(8'd9);
    convert(8'd10);
    convert(8'h80);
    convert(8'h7F);
    convert(8'd200);
    @(negedge clk);
    check("bcd_hold_idle", 32'(bcd), 32'(model(8'd200) & 13'h0fff));
    // start/bin activity while busy must be ignored
    nd = n_done;
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd123;
    sb.push_back(model(8'd123));
    @(negedge clk);
    start = 1'b0;
    for (int n = 2; n <= 12; n++) begin
      start = (n >= 2 && n <= 5);
      bin   = (n >= 2 && n <= 5) ? 8'd45 : 8'd0;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("single_done", 32'(n_done - nd), 32'd1);
    // start held high: back-to-back conversions
    start = 1'b1;
    bin   = 8'd200;
    sb.push_back(model(8'd200));
    d1 = 0; d2 = 0; nlow = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bin = 8'd37;
        sb.push_back(model(8'd37));
      end
      if (n == 10) start = 1'b0;
      if (done && d1 == 0) d1 = n;
      else if (done && d2 == 0) d2 = n;
      if (n <= 18 && !busy) begin
        nlow++;
        check("busy_low_only_done", 32'(done), 32'd1);
      end
    end
    check("first_done", 32'(d1), 32'd9);
    check("done_spacing", 32'(d2 - d1), 32'd9);
    check("busy_low_count", 32'(nlow), 32'd2);
    // reset mid-conversion aborts with no done
    nd = n_done;
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd99;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(n_done - nd), 32'd0);
    convert(8'd77);
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
